mux_cascade_pipe: RTL and testbench
===================================

MUX_CASCADE_PIPE -- requirements
Module: mux_cascade_pipe

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning data width per channel in bits (W >= 1).
REQ-002 The block SHALL have parameter N, default 4, meaning channel count (power of 2, N >= 2); SW = log2(N).
REQ-003 The block SHALL have parameter CW, default 16, meaning transfer-counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream beat is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 The block SHALL have port in_data, input, N*W bits: channel k at bits [k*W +: W].
REQ-009 The block SHALL have port sel_base, input, SW bits: the default channel select.
REQ-010 The block SHALL have port sel_alt, input, SW bits: the alternate channel select.
REQ-011 The block SHALL have port sel_pick, input, 1 bit: 1 chooses sel_alt, 0 chooses sel_base.
REQ-012 The block SHALL have port sel_hold, input, 1 bit: 1 reuses the last effective select.
REQ-013 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-015 The block SHALL have port out_data, output, W bits: the selected channel data.
REQ-016 The block SHALL have port out_sel, output, SW bits: the effective select used for out_data.
REQ-017 The block SHALL have port xfer_cnt, output, CW bits: count of completed output transfers.

Function
REQ-018 The block SHALL accept an input beat when in_valid && in_ready at a clock edge ("accept").
REQ-019 The block SHALL complete an output transfer when out_valid && out_ready at a clock edge ("transfer").
REQ-020 Stage 1 SHALL compute the effective select as: sel_hold ? held_sel : (sel_pick ? sel_alt : sel_base).
REQ-021 On accept, stage 1 SHALL register in_data and the effective select, and SHALL load held_sel with that effective select.
REQ-022 Stage 2 SHALL register out_data = channel[eff_sel] of the stage-1 data and out_sel = eff_sel.
REQ-023 Stage 2 SHALL advance (s2_adv) when !out_valid || out_ready.
REQ-024 Stage 1 SHALL advance when !s1_valid || s2_adv, and in_ready SHALL equal that term combinationally.
REQ-025 Latency SHALL be 2: a beat accepted at edge k has out_valid high after edge k+1 when out_ready is held 1.
REQ-026 With in_valid=1 and out_ready=1 continuously, throughput SHALL be one beat per cycle with no bubbles.
REQ-027 While out_valid && !out_ready, out_data, out_sel and out_valid SHALL hold stable.
REQ-028 A stage with no incoming beat SHALL clear its valid flag when it advances; data registers MAY hold stale values.
REQ-029 Simultaneous accept and transfer SHALL both take effect in the same cycle with no loss or duplication.
REQ-030 xfer_cnt SHALL increment by 1 on each transfer and SHALL wrap from 2^CW-1 to 0.
REQ-031 held_sel SHALL change only on accept; sel_hold with no accept SHALL have no effect.
REQ-032 Beats SHALL leave in acceptance order; the block SHALL NOT drop or reorder beats.

Reset
REQ-033 While rst=1 at an edge, stage valids SHALL clear, out_valid=0, out_data=0, out_sel=0, held_sel=0 and xfer_cnt=0.
REQ-034 A beat in flight when rst asserts SHALL be discarded and SHALL NOT appear at the output after reset.
REQ-035 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-036 The bench SHALL run this scenario (N=4, W=8): in_data=0x44332211, sel_base=2, sel_pick=0, out_ready=1, one beat -> out_data=0x33, out_sel=2, two edges after accept; xfer_cnt=1.
REQ-037 The bench SHALL run this scenario: sel_pick=1, sel_alt=3, sel_base=0, same data -> out_data=0x44, out_sel=3; then sel_hold=1, sel_base=1, sel_pick=0 -> out_sel=3, out_data=0x44.
REQ-038 The bench SHALL run this scenario: out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 beats accepted, then in_ready=0; outputs stable; after out_ready=1, all beats arrive in order.
REQ-039 The bench SHALL run this scenario: 100 back-to-back beats with random selects and out_ready=1 -> 100 outputs matching the reference model; xfer_cnt=100.
REQ-040 The bench SHALL run this scenario: CW=4, 17 transfers -> xfer_cnt=1.
REQ-041 The bench SHALL run this scenario: assert rst with 2 beats in flight -> out_valid=0 and out_sel=0 next cycle; no stale beat after release; held_sel=0, so sel_hold=1 on the first beat yields out_sel=0.

Source files
------------

// File: rtl/mux_cascade_pipe.sv
// rtl/mux_cascade_pipe.sv - two-stage pipelined channel mux with held select and transfer counter
// Stage 1 latches the beat and its effective select; stage 2 registers the chosen channel.
module mux_cascade_pipe #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int CW = 16,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_data,
  input  logic [SW-1:0]   sel_base,
  input  logic [SW-1:0]   sel_alt,
  input  logic            sel_pick,
  input  logic            sel_hold,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_sel,
  output logic [CW-1:0]   xfer_cnt
);

  logic            s1_valid;
  logic [N*W-1:0]  s1_data;
  logic [SW-1:0]   s1_sel;
  logic [SW-1:0]   held_sel;
  logic [SW-1:0]   eff_sel;
  logic [W-1:0]    s1_mux;
  logic            s1_adv;
  logic            s2_adv;

  assign eff_sel  = sel_hold ? held_sel : (sel_pick ? sel_alt : sel_base);
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    s1_mux = '0;
    for (int k = 0; k < N; k++) begin
      if (s1_sel == SW'(k)) s1_mux = s1_data[k*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_sel    <= '0;
      held_sel  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      xfer_cnt  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data  <= in_data;
          s1_sel   <= eff_sel;
          held_sel <= eff_sel;
        end
      end
      // Data registers keep stale contents when a bubble moves through.
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= s1_mux;
          out_sel  <= s1_sel;
        end
      end
      if (out_valid && out_ready) xfer_cnt <= xfer_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_mux_cascade_pipe.sv
// tb/tb_mux_cascade_pipe.sv - scoreboard bench for mux_cascade_pipe
// Two instances share stimulus: CW=16 for counting, CW=4 for counter wrap.
module tb_mux_cascade_pipe;

  typedef struct {
    logic [7:0] data;
    logic [1:0] sel;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  sel_base, sel_alt;
  logic        sel_pick, sel_hold;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic [15:0] xfer_cnt;

  logic        in_ready4, out_valid4;
  logic [7:0]  out_data4;
  logic [1:0]  out_sel4;
  logic [3:0]  xfer_cnt4;

  int   checks = 0;
  int   errors = 0;
  int   stalls = 0;
  exp_t exp_q[$];
  logic [1:0] held_model = 2'd0;

  always #5 clk = ~clk;

  mux_cascade_pipe #(.W(8), .N(4), .CW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sel_base(sel_base), .sel_alt(sel_alt), .sel_pick(sel_pick), .sel_hold(sel_hold),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel),
    .xfer_cnt(xfer_cnt)
  );

  mux_cascade_pipe #(.W(8), .N(4), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .sel_base(sel_base), .sel_alt(sel_alt), .sel_pick(sel_pick), .sel_hold(sel_hold),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_sel(out_sel4),
    .xfer_cnt(xfer_cnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] chan(input logic [31:0] d, input logic [1:0] s);
    return d[int'(s)*8 +: 8];
  endfunction

  // Monitor: a transfer is due at the next rising edge whenever valid && ready here.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data=%0h sel=%0d expected no beat", out_data, out_sel);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_sel", out_sel, e.sel);
        chk("out_data_cw4", out_data4, e.data);
        chk("out_sel_cw4", out_sel4, e.sel);
        chk("out_valid_cw4", out_valid4, 1);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid left high.
  task automatic send(input logic [31:0] d, input logic [1:0] b, input logic [1:0] a,
                      input logic p, input logic h);
    int n;
    logic [1:0] eff;
    exp_t e;
    in_valid = 1'b1; in_data = d; sel_base = b; sel_alt = a; sel_pick = p; sel_hold = h;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    stalls += n;
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 after %0d cycles", n);
    end else begin
      eff = h ? held_model : (p ? a : b);
      held_model = eff;
      e.data = chan(d, eff);
      e.sel  = eff;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    held_model = 2'd0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int acc;
    logic have;
    logic [7:0] snap_d;
    logic [1:0] snap_s;
    logic [31:0] d;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; sel_base = '0; sel_alt = '0;
    sel_pick = 1'b0; sel_hold = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    // Basic select and 2-cycle latency
    send(32'h44332211, 2'd2, 2'd0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_s1_only", out_valid, 0);
    @(negedge clk);
    chk("latency_out_valid", out_valid, 1);
    @(posedge clk); #1;
    chk("xfer_cnt_one", xfer_cnt, 1);
    drain();

    // Alternate select, then held select
    send(32'h44332211, 2'd0, 2'd3, 1'b1, 1'b0);
    send(32'h44332211, 2'd1, 2'd0, 1'b0, 1'b1);
    drain();

    // Backpressure: only two beats fit, outputs frozen
    out_ready = 1'b0;
    acc = 0;
    have = 1'b0;
    snap_d = '0;
    snap_s = '0;
    for (int i = 0; i < 5; i++) begin
      d = 32'h03020100 + 32'h10101010 * acc;
      in_valid = 1'b1; in_data = d; sel_base = 2'(acc); sel_pick = 1'b0; sel_hold = 1'b0;
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{data: chan(d, 2'(acc)), sel: 2'(acc)});
        held_model = 2'(acc);
        acc++;
      end
      if (out_valid) begin
        if (!have) begin
          have = 1'b1; snap_d = out_data; snap_s = out_sel;
        end else begin
          chk("stall_data_stable", out_data, snap_d);
          chk("stall_sel_stable", out_sel, snap_s);
          chk("stall_valid_stable", out_valid, 1);
        end
      end
      @(posedge clk); #1;
    end
    chk("stall_accepted", acc, 2);
    @(negedge clk);
    chk("stall_in_ready", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // 100 back-to-back random beats
    do_reset();
    stalls = 0;
    for (int i = 0; i < 100; i++)
      send($urandom, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    drain();
    chk("xfer_cnt_100", xfer_cnt, 100);
    chk("xfer_cnt4_100", xfer_cnt4, 4);
    chk("no_bubbles", stalls, 0);

    // Counter wrap for CW=4
    do_reset();
    for (int i = 0; i < 17; i++)
      send(32'h0 + 32'h01010101 * i, 2'(i), 2'd0, 1'b0, 1'b0);
    drain();
    chk("xfer_cnt4_wrap", xfer_cnt4, 1);
    chk("xfer_cnt_17", xfer_cnt, 17);

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(32'hAABBCCDD, 2'd3, 2'd0, 1'b0, 1'b0);
    send(32'h11223344, 2'd3, 2'd0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    held_model = 2'd0;
    @(negedge clk);
    chk("inflight_before_rst", out_valid, 1);
    @(negedge clk);
    chk("rst_flush_valid", out_valid, 0);
    chk("rst_flush_sel", out_sel, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_stale_beat", out_valid, 0);
    end
    @(posedge clk); #1;
    send(32'h44332211, 2'd1, 2'd2, 1'b1, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded limit");
    $fatal(1, "timeout");
  end

endmodule
